// File: rtl/uart_rx_if.sv
// Receiver-side bundle of the UART RX block: serial line in, byte/frame results out.
// The slave modport is the receiver; the master modport is whoever drives the line.
interface uart_rx_if #(
  parameter int MEMORY_LENGTH = 4
);
  logic                         uart_rx;
  logic [7:0]                   rx_byte;
  logic                         byte_valid;
  logic [MEMORY_LENGTH*8-1:0]   dataReceived;
  logic                         frame_done;
  logic                         framing_error;

  modport master (
    output uart_rx,
    input  rx_byte,
    input  byte_valid,
    input  dataReceived,
    input  frame_done,
    input  framing_error
  );

  modport slave (
    input  uart_rx,
    output rx_byte,
    output byte_valid,
    output dataReceived,
    output frame_done,
    output framing_error
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, break/framing handling and assembly of
// MEMORY_LENGTH consecutive bytes into one wide word.
module uart_rx #(
  parameter int DELAY_FRAMES  = 234,
  parameter int MEMORY_LENGTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  localparam int CW      = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam int BIW     = (MEMORY_LENGTH > 1) ? $clog2(MEMORY_LENGTH) : 1;
  localparam int HALF_M1 = (DELAY_FRAMES / 2 > 0) ? (DELAY_FRAMES / 2 - 1) : 0;
  localparam int FULL_M1 = (DELAY_FRAMES > 0) ? (DELAY_FRAMES - 1) : 0;

  localparam logic [CW-1:0]  CNT_HALF = CW'(HALF_M1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FULL_M1);
  localparam logic [BIW-1:0] IDX_LAST = BIW'(MEMORY_LENGTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  logic                       sync1_q;
  logic                       rx_s_q;

  state_t                     state_q,         state_d;
  logic [CW-1:0]              cnt_q,           cnt_d;
  logic [2:0]                 bit_idx_q,       bit_idx_d;
  logic [7:0]                 shift_q,         shift_d;
  logic [BIW-1:0]             byte_idx_q,      byte_idx_d;
  logic [7:0]                 rx_byte_q,       rx_byte_d;
  logic [MEMORY_LENGTH*8-1:0] data_q,          data_d;
  logic                       byte_valid_q,    byte_valid_d;
  logic                       frame_done_q,    frame_done_d;
  logic                       framing_error_q, framing_error_d;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_idx_d      = byte_idx_q;
    rx_byte_d       = rx_byte_q;
    data_d          = data_q;
    byte_valid_d    = 1'b0;
    frame_done_d    = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          // A start bit that is high again at its midpoint was noise
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d      = ST_IDLE;
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
            for (int k = 0; k < MEMORY_LENGTH; k++) begin
              if (byte_idx_q == BIW'(k)) begin
                data_d[8*k +: 8] = shift_q;
              end else begin
                data_d[8*k +: 8] = data_q[8*k +: 8];
              end
            end
            if (byte_idx_q == IDX_LAST) begin
              frame_done_d = 1'b1;
              byte_idx_d   = '0;
            end else begin
              byte_idx_d = byte_idx_q + BIW'(1);
            end
          end else begin
            // Bad stop bit: drop the byte and wait out any break condition
            state_d         = ST_WAIT_IDLE;
            framing_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Receiver state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      byte_idx_q      <= '0;
      rx_byte_q       <= 8'h00;
      data_q          <= '0;
      byte_valid_q    <= 1'b0;
      frame_done_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_idx_q      <= byte_idx_d;
      rx_byte_q       <= rx_byte_d;
      data_q          <= data_d;
      byte_valid_q    <= byte_valid_d;
      frame_done_q    <= frame_done_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign bus.rx_byte       = rx_byte_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.dataReceived  = data_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames on the serial line and checks
// bytes, frame assembly, glitch/framing/reset behaviour and pulse widths.
module tb_uart_rx;

  localparam int D  = 234;
  localparam int ML = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  int   cyc;
  int   nbv, nfd, nfe, ncoinc;
  int   run_bv, run_fd, run_fe;
  int   max_bv, max_fd, max_fe;
  int   bv_cyc;
  int   fall_cyc;

  uart_rx_if #(.MEMORY_LENGTH(ML)) bus ();

  uart_rx #(
    .DELAY_FRAMES  (D),
    .MEMORY_LENGTH (ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and run-length tracking, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) begin
      nbv    = nbv + 1;
      bv_cyc = cyc;
      run_bv = run_bv + 1;
    end else begin
      run_bv = 0;
    end
    if (bus.frame_done === 1'b1) begin
      nfd    = nfd + 1;
      run_fd = run_fd + 1;
      if (bus.byte_valid === 1'b1) ncoinc = ncoinc + 1;
    end else begin
      run_fd = 0;
    end
    if (bus.framing_error === 1'b1) begin
      nfe    = nfe + 1;
      run_fe = run_fe + 1;
    end else begin
      run_fe = 0;
    end
    if (run_bv > max_bv) max_bv = run_bv;
    if (run_fd > max_fd) max_fd = run_fd;
    if (run_fe > max_fe) max_fe = run_fe;
  end

  task automatic clear_counts();
    @(negedge clk);
    nbv = 0; nfd = 0; nfe = 0; ncoinc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    bus.uart_rx = 1'b1;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    idle(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input int period, input logic stop);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    fall_cyc = cyc;
    idle(period);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      idle(period);
    end
    bus.uart_rx = stop;
    idle(period);
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_vec++; if (bus.rx_byte !== 8'h00) begin n_miss++; $display("FAIL reset_rx_byte got %h want 00", bus.rx_byte); end
    n_vec++; if (bus.dataReceived !== 32'h0) begin n_miss++; $display("FAIL reset_data got %h want 00000000", bus.dataReceived); end
    n_vec++; if (bus.byte_valid !== 1'b0) begin n_miss++; $display("FAIL reset_byte_valid got %b want 0", bus.byte_valid); end
    n_vec++; if (bus.frame_done !== 1'b0) begin n_miss++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    n_vec++; if (bus.framing_error !== 1'b0) begin n_miss++; $display("FAIL reset_framing_error got %b want 0", bus.framing_error); end
  endtask

  task automatic test_single();
    int lat;
    clear_counts();
    send_byte(8'h55, D, 1'b1);
    idle(20);
    lat = bv_cyc - fall_cyc;
    n_vec++; if (bus.rx_byte !== 8'h55) begin n_miss++; $display("FAIL single_rx_byte got %h want 55", bus.rx_byte); end
    n_vec++; if (nbv !== 1) begin n_miss++; $display("FAIL single_bv_count got %0d want 1", nbv); end
    n_vec++; if (bus.dataReceived[7:0] !== 8'h55) begin n_miss++; $display("FAIL single_slot0 got %h want 55", bus.dataReceived[7:0]); end
    n_vec++; if (nfd !== 0) begin n_miss++; $display("FAIL single_frame_done got %0d want 0", nfd); end
    n_vec++; if (nfe !== 0) begin n_miss++; $display("FAIL single_framing_error got %0d want 0", nfe); end
    n_vec++; if (lat < 2 + D/2 + 9*D - 1 || lat > 2 + D/2 + 9*D + 1) begin
      n_miss++; $display("FAIL single_latency got %0d want %0d+-1", lat, 2 + D/2 + 9*D);
    end
  endtask

  task automatic test_frame_group();
    apply_reset(1);
    clear_counts();
    send_byte(8'h11, D, 1'b1);
    send_byte(8'h22, D, 1'b1);
    send_byte(8'h33, D, 1'b1);
    send_byte(8'h44, D, 1'b1);
    idle(20);
    n_vec++; if (nbv !== 4) begin n_miss++; $display("FAIL group_bv_count got %0d want 4", nbv); end
    n_vec++; if (nfd !== 1) begin n_miss++; $display("FAIL group_frame_done got %0d want 1", nfd); end
    n_vec++; if (ncoinc !== 1) begin n_miss++; $display("FAIL group_coincident got %0d want 1", ncoinc); end
    n_vec++; if (bus.dataReceived !== 32'h44332211) begin n_miss++; $display("FAIL group_data got %h want 44332211", bus.dataReceived); end
    n_vec++; if (bus.rx_byte !== 8'h44) begin n_miss++; $display("FAIL group_rx_byte got %h want 44", bus.rx_byte); end
    send_byte(8'h99, D, 1'b1);
    idle(20);
    n_vec++; if (bus.dataReceived !== 32'h44332299) begin n_miss++; $display("FAIL group_wrap got %h want 44332299", bus.dataReceived); end
    n_vec++; if (nfd !== 1) begin n_miss++; $display("FAIL group_wrap_fd got %0d want 1", nfd); end
  endtask

  task automatic test_glitch();
    clear_counts();
    @(negedge clk);
    bus.uart_rx = 1'b0;
    idle(50);
    bus.uart_rx = 1'b1;
    idle(2*D);
    n_vec++; if (nbv !== 0) begin n_miss++; $display("FAIL glitch_bv got %0d want 0", nbv); end
    n_vec++; if (nfe !== 0) begin n_miss++; $display("FAIL glitch_fe got %0d want 0", nfe); end
    n_vec++; if (nfd !== 0) begin n_miss++; $display("FAIL glitch_fd got %0d want 0", nfd); end
    n_vec++; if (bus.rx_byte !== 8'h99) begin n_miss++; $display("FAIL glitch_rx_byte got %h want 99", bus.rx_byte); end
    n_vec++; if (bus.dataReceived !== 32'h44332299) begin n_miss++; $display("FAIL glitch_data got %h want 44332299", bus.dataReceived); end
    // Line still usable: next byte lands in slot 1
    send_byte(8'h5A, D, 1'b1);
    idle(20);
    n_vec++; if (bus.dataReceived !== 32'h44335A99) begin n_miss++; $display("FAIL glitch_after got %h want 44335A99", bus.dataReceived); end
  endtask

  task automatic test_framing();
    apply_reset(1);
    clear_counts();
    send_byte(8'hA5, D, 1'b0);
    idle(1000);
    n_vec++; if (nfe !== 1) begin n_miss++; $display("FAIL frame_err_count got %0d want 1", nfe); end
    n_vec++; if (nbv !== 0) begin n_miss++; $display("FAIL frame_err_bv got %0d want 0", nbv); end
    n_vec++; if (bus.dataReceived !== 32'h0) begin n_miss++; $display("FAIL frame_err_data got %h want 00000000", bus.dataReceived); end
    bus.uart_rx = 1'b1;
    idle(D);
    send_byte(8'h3C, D, 1'b1);
    idle(20);
    n_vec++; if (nbv !== 1) begin n_miss++; $display("FAIL frame_next_bv got %0d want 1", nbv); end
    n_vec++; if (bus.rx_byte !== 8'h3C) begin n_miss++; $display("FAIL frame_next_rx got %h want 3C", bus.rx_byte); end
    n_vec++; if (bus.dataReceived !== 32'h0000003C) begin n_miss++; $display("FAIL frame_next_data got %h want 0000003C", bus.dataReceived); end
    n_vec++; if (nfe !== 1) begin n_miss++; $display("FAIL frame_next_fe got %0d want 1", nfe); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11, D, 1'b1);
    idle(20);
    clear_counts();
    @(negedge clk);
    bus.uart_rx = 1'b0;
    idle(D);
    bus.uart_rx = 1'b1;
    idle(4*D + D/2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5*D);
    n_vec++; if (nbv !== 0) begin n_miss++; $display("FAIL rstmid_bv got %0d want 0", nbv); end
    n_vec++; if (nfe !== 0) begin n_miss++; $display("FAIL rstmid_fe got %0d want 0", nfe); end
    n_vec++; if (bus.dataReceived !== 32'h0) begin n_miss++; $display("FAIL rstmid_data got %h want 00000000", bus.dataReceived); end
    send_byte(8'h81, D, 1'b1);
    idle(20);
    n_vec++; if (nbv !== 1) begin n_miss++; $display("FAIL rstmid_next_bv got %0d want 1", nbv); end
    n_vec++; if (bus.rx_byte !== 8'h81) begin n_miss++; $display("FAIL rstmid_next_rx got %h want 81", bus.rx_byte); end
    n_vec++; if (bus.dataReceived !== 32'h00000081) begin n_miss++; $display("FAIL rstmid_next_data got %h want 00000081", bus.dataReceived); end
  endtask

  task automatic test_margin();
    apply_reset(1);
    clear_counts();
    send_byte(8'h96, D + 4, 1'b1);
    idle(D);
    n_vec++; if (bus.rx_byte !== 8'h96) begin n_miss++; $display("FAIL margin_slow_rx got %h want 96", bus.rx_byte); end
    send_byte(8'h96, D - 4, 1'b1);
    idle(D);
    n_vec++; if (bus.dataReceived !== 32'h00009696) begin n_miss++; $display("FAIL margin_fast_data got %h want 00009696", bus.dataReceived); end
    n_vec++; if (nbv !== 2 || nfe !== 0) begin n_miss++; $display("FAIL margin_counts got bv=%0d fe=%0d want bv=2 fe=0", nbv, nfe); end
  endtask

  task automatic test_pulse_width();
    n_vec++; if (max_bv > 1) begin n_miss++; $display("FAIL width_byte_valid got %0d want <=1", max_bv); end
    n_vec++; if (max_fd > 1) begin n_miss++; $display("FAIL width_frame_done got %0d want <=1", max_fd); end
    n_vec++; if (max_fe > 1) begin n_miss++; $display("FAIL width_framing_error got %0d want <=1", max_fe); end
  endtask

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0;
    nbv = 0; nfd = 0; nfe = 0; ncoinc = 0;
    run_bv = 0; run_fd = 0; run_fe = 0;
    max_bv = 0; max_fd = 0; max_fe = 0;
    bv_cyc = 0; fall_cyc = 0;
    rst = 1'b1;
    bus.uart_rx = 1'b1;
    test_reset();
    test_single();
    test_frame_group();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_margin();
    test_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
